// File: rtl/cordic_scheduler.sv
// Round-robin front end that shares one iterative CORDIC core between NUM_REQ requesters.
// Define CORDIC_SCHED_TIMEOUT_EN to add the WAIT-state watchdog (TIMEOUT_CYCLES).
module cordic_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int FIXED_WIDTH    = 16,
    parameter int SHIFT_W        = $clog2(FIXED_WIDTH) + 1,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_mode,
    input  logic [NUM_REQ-1:0]             req_rot,
    input  logic [SHIFT_W*NUM_REQ-1:0]     req_shift,
    input  logic [FIXED_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [FIXED_WIDTH*NUM_REQ-1:0] req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [FIXED_WIDTH-1:0]         rsp_out1,
    output logic [FIXED_WIDTH-1:0]         rsp_out2,
    output logic                           rsp_error,
    output logic                           core_start,
    output logic [1:0]                     core_mode,
    output logic                           core_is_rotating,
    output logic [SHIFT_W-1:0]             core_alpha_shift,
    output logic [FIXED_WIDTH-1:0]         core_a,
    output logic [FIXED_WIDTH-1:0]         core_b,
    input  logic [FIXED_WIDTH-1:0]         core_out1,
    input  logic [FIXED_WIDTH-1:0]         core_out2,
    input  logic                           core_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        w_win;
    logic                   w_any;
    logic                   w_accept;
    logic                   w_tmo;

    logic [1:0]             w_sel_mode;
    logic                   w_sel_rot;
    logic [SHIFT_W-1:0]     w_sel_shift;
    logic [FIXED_WIDTH-1:0] w_sel_a;
    logic [FIXED_WIDTH-1:0] w_sel_b;

    logic [ID_W-1:0]        r_cfg_id;
    logic [1:0]             r_cfg_mode;
    logic                   r_cfg_rot;
    logic [SHIFT_W-1:0]     r_cfg_shift;
    logic [FIXED_WIDTH-1:0] r_cfg_a;
    logic [FIXED_WIDTH-1:0] r_cfg_b;
    logic [FIXED_WIDTH-1:0] r_out1;
    logic [FIXED_WIDTH-1:0] r_out2;

    // Two passes: indices above the last winner first, then wrap from 0.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any && req_valid[i] && (ID_W'(i) > r_rr_ptr)) begin
                w_any = 1'b1;
                w_win = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any && req_valid[i] && (ID_W'(i) <= r_rr_ptr)) begin
                w_any = 1'b1;
                w_win = ID_W'(i);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_any;

    always_comb begin
        req_ready   = '0;
        w_sel_mode  = '0;
        w_sel_rot   = 1'b0;
        w_sel_shift = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                req_ready[i] = w_accept;
                w_sel_mode   = req_mode[2*i +: 2];
                w_sel_rot    = req_rot[i];
                w_sel_shift  = req_shift[SHIFT_W*i +: SHIFT_W];
                w_sel_a      = req_a[FIXED_WIDTH*i +: FIXED_WIDTH];
                w_sel_b      = req_b[FIXED_WIDTH*i +: FIXED_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        core_start = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                core_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (core_done || w_tmo) w_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_cfg_id    <= '0;
            r_cfg_mode  <= '0;
            r_cfg_rot   <= 1'b0;
            r_cfg_shift <= '0;
            r_cfg_a     <= '0;
            r_cfg_b     <= '0;
            r_out1      <= '0;
            r_out2      <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr    <= w_win;
                r_cfg_id    <= w_win;
                r_cfg_mode  <= w_sel_mode;
                r_cfg_rot   <= w_sel_rot;
                r_cfg_shift <= w_sel_shift;
                r_cfg_a     <= w_sel_a;
                r_cfg_b     <= w_sel_b;
            end
            if (r_state == S_WAIT) begin
                if (core_done) begin
                    r_out1 <= core_out1;
                    r_out2 <= core_out2;
                end else if (w_tmo) begin
                    r_out1 <= '0;
                    r_out2 <= '0;
                end
            end
        end
    end

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_tmo_cnt;
    logic          r_err;

    assign w_tmo = (r_state == S_WAIT) && (r_tmo_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (r_state == S_WAIT) begin
                if (core_done) begin
                    r_err <= 1'b0;
                end else if (w_tmo) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign rsp_error = r_err;
`else
    assign w_tmo     = 1'b0;
    assign rsp_error = 1'b0;
`endif

    assign rsp_valid        = (r_state == S_RESP);
    assign rsp_id           = r_cfg_id;
    assign rsp_out1         = r_out1;
    assign rsp_out2         = r_out2;
    assign core_mode        = r_cfg_mode;
    assign core_is_rotating = r_cfg_rot;
    assign core_alpha_shift = r_cfg_shift;
    assign core_a           = r_cfg_a;
    assign core_b           = r_cfg_b;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler: behavioural CORDIC stub, arbiter/latency
// model checked every cycle, plus literal expectations from the test plan.
module tb_cordic_scheduler;

    localparam int NR       = 4;
    localparam int FW       = 16;
    localparam int SW       = 5;
    localparam int IW       = 2;
    localparam int TMO      = 32;
    localparam int CORE_LAT = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [2*NR-1:0]   req_mode;
    logic [NR-1:0]     req_rot;
    logic [SW*NR-1:0]  req_shift;
    logic [FW*NR-1:0]  req_a;
    logic [FW*NR-1:0]  req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [FW-1:0]     rsp_out1;
    logic [FW-1:0]     rsp_out2;
    logic              rsp_error;
    logic              core_start;
    logic [1:0]        core_mode;
    logic              core_is_rotating;
    logic [SW-1:0]     core_alpha_shift;
    logic [FW-1:0]     core_a;
    logic [FW-1:0]     core_b;
    logic [FW-1:0]     core_out1;
    logic [FW-1:0]     core_out2;
    logic              core_done;

    logic [1:0]        t_mode  [NR];
    logic              t_rot   [NR];
    logic [SW-1:0]     t_sh    [NR];
    logic [FW-1:0]     t_a     [NR];
    logic [FW-1:0]     t_b     [NR];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_mode[2*i +: 2]   = t_mode[i];
            req_rot[i]           = t_rot[i];
            req_shift[SW*i +: SW] = t_sh[i];
            req_a[FW*i +: FW]    = t_a[i];
            req_b[FW*i +: FW]    = t_b[i];
        end
    end

    cordic_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_mode         (req_mode),
        .req_rot          (req_rot),
        .req_shift        (req_shift),
        .req_a            (req_a),
        .req_b            (req_b),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_out1         (rsp_out1),
        .rsp_out2         (rsp_out2),
        .rsp_error        (rsp_error),
        .core_start       (core_start),
        .core_mode        (core_mode),
        .core_is_rotating (core_is_rotating),
        .core_alpha_shift (core_alpha_shift),
        .core_a           (core_a),
        .core_b           (core_b),
        .core_out1        (core_out1),
        .core_out2        (core_out2),
        .core_done        (core_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Core behaviour: circular -> cos/sin of A, linear -> A*B>>shift, else sum/diff.
    function automatic logic [31:0] core_calc(logic [1:0] md, logic [SW-1:0] sh,
                                              logic [FW-1:0] a, logic [FW-1:0] b);
        real sc;
        real ang;
        int  p;
        int  o1;
        int  o2;
        sc = $itor(1 << sh);
        case (md)
            2'd0: begin
                ang = $itor($signed(a)) / sc;
                o1  = int'($cos(ang) * sc);
                o2  = int'($sin(ang) * sc);
            end
            2'd1: begin
                p  = $signed(a) * $signed(b);
                o1 = p >>> sh;
                o2 = $signed(b);
            end
            default: begin
                o1 = int'(a) + int'(b);
                o2 = int'(a) - int'(b);
            end
        endcase
        return {o1[15:0], o2[15:0]};
    endfunction

    logic r_kill;
    logic r_stray;
    logic r_done;
    int   r_ccnt;

    assign core_done = r_done | r_stray;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ccnt    <= 0;
            r_done    <= 1'b0;
            core_out1 <= '0;
            core_out2 <= '0;
        end else begin
            r_done <= 1'b0;
            if (core_start) begin
                r_ccnt <= CORE_LAT;
            end else if (r_ccnt > 0) begin
                r_ccnt <= r_ccnt - 1;
                if (r_ccnt == 1 && !r_kill) begin
                    r_done <= 1'b1;
                    {core_out1, core_out2} <= core_calc(core_mode, core_alpha_shift,
                                                        core_a, core_b);
                end
            end
        end
    end

    int r_cyc = 0;
    always @(posedge clk) r_cyc <= r_cyc + 1;

    int          m_last = NR - 1;
    bit          m_busy = 0;
    int          m_age  = 0;
    int          m_lat  = CORE_LAT + 3;
    logic [IW-1:0] m_id;
    logic [1:0]  m_mode;
    logic        m_rot;
    logic [SW-1:0] m_sh;
    logic [FW-1:0] m_a;
    logic [FW-1:0] m_b;
    logic [31:0] m_res;
    logic        m_err;
    int          grants[$];
    int          n_starts = 0;
    int          acc_cyc  = 0;
    int          l_lat    = 0;
    bit          seen_rsp = 0;
    logic [IW-1:0] l_id;
    logic [FW-1:0] l_out1;
    logic [FW-1:0] l_out2;
    logic        l_err;

    always @(negedge clk) begin
        logic [NR-1:0] er;
        int w;
        int i;
        if (rst) begin
            m_busy = 0;
            m_last = NR - 1;
            chk("rst_ctl", {req_ready, rsp_valid, rsp_error, rsp_id, core_start,
                            core_mode, core_is_rotating, core_alpha_shift}, '0);
            chk("rst_out", {rsp_out1, rsp_out2, core_a, core_b}, '0);
        end else begin
            if (m_busy) m_age++;
            er = '0;
            w  = -1;
            if (!m_busy) begin
                for (int k = 1; k <= NR; k++) begin
                    i = (m_last + k) % NR;
                    if (w < 0 && req_valid[i]) w = i;
                end
            end
            if (w >= 0) er[w] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("core_start", core_start, m_busy && m_age == 1);
            chk("rsp_valid", rsp_valid, m_busy && m_age >= m_lat);
            if (m_busy && m_age >= 1 && m_age < m_lat)
                chk("core_cfg", {core_mode, core_is_rotating, core_alpha_shift, core_a, core_b},
                    {m_mode, m_rot, m_sh, m_a, m_b});
            if (m_busy && m_age >= m_lat) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_out", {rsp_out1, rsp_out2}, m_res);
                chk("rsp_error", rsp_error, m_err);
                if (!seen_rsp) begin
                    l_lat    = r_cyc - acc_cyc;
                    seen_rsp = 1;
                end
            end
            if (core_start) n_starts++;
            if (rsp_valid && rsp_ready) begin
                l_id   = rsp_id;
                l_out1 = rsp_out1;
                l_out2 = rsp_out2;
                l_err  = rsp_error;
            end
            if (m_busy && m_age >= m_lat && rsp_ready) begin
                m_busy = 0;
            end else if (w >= 0) begin
                m_busy   = 1;
                m_age    = 0;
                m_last   = w;
                m_id     = IW'(w);
                m_mode   = t_mode[w];
                m_rot    = t_rot[w];
                m_sh     = t_sh[w];
                m_a      = t_a[w];
                m_b      = t_b[w];
                acc_cyc  = r_cyc + 1;
                seen_rsp = 0;
                grants.push_back(w);
                if (r_kill) begin
                    m_lat = TMO + 3;
                    m_res = '0;
                    m_err = 1'b1;
                end else begin
                    m_lat = CORE_LAT + 3;
                    m_res = core_calc(m_mode, m_sh, m_a, m_b);
                    m_err = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(int id, logic [1:0] md, logic rt, logic [SW-1:0] sh,
                          logic [FW-1:0] a, logic [FW-1:0] b);
        t_mode[id] = md;
        t_rot[id]  = rt;
        t_sh[id]   = sh;
        t_a[id]    = a;
        t_b[id]    = b;
    endtask

    task automatic issue(int id, logic [1:0] md, logic rt, logic [SW-1:0] sh,
                         logic [FW-1:0] a, logic [FW-1:0] b);
        bit got;
        got = 0;
        set_op(id, md, rt, sh, a, b);
        req_valid[id] = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1;
                break;
            end
        end
        chk("grant_wait", got, 1);
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_done(int lim);
        for (int c = 0; c < lim; c++) begin
            @(posedge clk);
            if (!m_busy) break;
        end
        chk("done_wait", m_busy, 0);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int gexp[6];
        logic [63:0] held;
        bit found;
        gexp = '{0, 1, 2, 3, 0, 1};
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        r_kill    = 1'b0;
        r_stray   = 1'b0;
        for (int i = 0; i < NR; i++) set_op(i, 2'd0, 1'b0, '0, '0, '0);
        repeat (3) tick();
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_core_start", core_start, 0);
        rst = 1'b0;
        tick();

        s0 = n_starts;
        issue(0, 2'd0, 1'b1, 5'd14, 16'h2182, 16'h0000);
        wait_done(100);
        chk("t1_starts", n_starts - s0, 1);
        chk("t1_latency", l_lat, 11);
        chk("t1_id", l_id, 0);
        chk("t1_out1_tol", (int'(l_out1) >= 'h376D - 8) && (int'(l_out1) <= 'h376D + 8), 1);
        chk("t1_out2_tol", (int'(l_out2) >= 'h2000 - 8) && (int'(l_out2) <= 'h2000 + 8), 1);

        r_stray = 1'b1;
        tick();
        r_stray = 1'b0;
        repeat (3) tick();
        chk("stray_done_ignored", rsp_valid, 0);

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        grants.delete();
        set_op(0, 2'd0, 1'b1, 5'd14, 16'h1000, 16'h0000);
        set_op(1, 2'd1, 1'b0, 5'd4,  16'h0123, 16'h0040);
        set_op(2, 2'd2, 1'b0, 5'd10, 16'h0500, 16'h0100);
        set_op(3, 2'd1, 1'b0, 5'd2,  16'hFFF0, 16'h0007);
        req_valid = '1;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            if (grants.size() >= 6) break;
        end
        #1;
        req_valid = '0;
        wait_done(100);
        chk("fair_count", grants.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < grants.size()) chk("fair_order", grants[k], gexp[k]);
        end

        issue(1, 2'd1, 1'b0, 5'd8, 16'h0300, 16'h0200);
        wait_done(100);
        chk("t3_out1", l_out1, 16'h0600);
        chk("t3_id", l_id, 1);

        rsp_ready = 1'b0;
        issue(3, 2'd2, 1'b0, 5'd6, 16'h0A00, 16'h0300);
        set_op(2, 2'd1, 1'b1, 5'd3, 16'h0040, 16'h0011);
        req_valid[2] = 1'b1;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1;
                break;
            end
        end
        chk("bp_rsp_seen", found, 1);
        held = {rsp_id, rsp_out1, rsp_out2};
        repeat (20) begin
            @(negedge clk);
            chk("bp_stable", {rsp_valid, rsp_id, rsp_out1, rsp_out2}, {1'b1, held[33:0]});
            chk("bp_no_grant", req_ready, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_xfer", rsp_valid, 1);
        @(negedge clk);
        chk("bp_next_grant", req_ready, 4'b0100);
        tick();
        req_valid[2] = 1'b0;
        wait_done(100);
        chk("bp_req2_id", l_id, 2);

        issue(0, 2'd0, 1'b1, 5'd14, 16'h1000, 16'h0000);
        tick();
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", {rsp_valid, rsp_id, core_start, core_mode,
                            core_is_rotating, core_alpha_shift}, '0);
        chk("rst_mid_data", {rsp_out1, rsp_out2, core_a, core_b}, '0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (15) tick();
        chk("rst_no_rsp", rsp_valid, 0);
        issue(2, 2'd2, 1'b0, 5'd14, 16'h0100, 16'h0040);
        wait_done(100);
        chk("post_rst_id", l_id, 2);
        chk("post_rst_out", {l_out1, l_out2}, {16'h0140, 16'h00C0});

`ifdef CORDIC_SCHED_TIMEOUT_EN
        r_kill = 1'b1;
        issue(1, 2'd1, 1'b0, 5'd8, 16'h0300, 16'h0200);
        wait_done(200);
        r_kill = 1'b0;
        chk("tmo_latency", l_lat, 34);
        chk("tmo_error", l_err, 1);
        chk("tmo_out", {l_out1, l_out2}, '0);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
